// File: rtl/lfsr_cipher_ctrl.sv
// One-character-at-a-time LFSR shift cipher controller with valid/ready handshakes.
// Optional build macro: CASE_PRESERVE_EN (restore lowercase on output).
module lfsr_cipher_ctrl #(
    parameter logic [7:0] SEED_DEFAULT = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_ch,
    input  logic        decrypt,
    input  logic        seed_load,
    input  logic [7:0]  seed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_ch,
    output logic        busy,
    output logic [15:0] letter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_KEY,
        S_SHIFT,
        S_OUT
    } state_t;

    state_t      r_state;
    logic [7:0]  r_ch;
    logic        r_dec;
    logic [7:0]  r_idx;
    logic        r_is_letter;
`ifdef CASE_PRESERVE_EN
    logic        r_was_lower;
`endif
    logic [7:0]  r_k;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_out_ch;
    logic        r_out_valid;
    logic [15:0] r_count;

    logic        w_lower;
    logic [7:0]  w_upper;
    logic        w_is_letter;
    logic [7:0]  w_raw;
    logic [7:0]  w_mod;
    logic [7:0]  w_c;
    logic [7:0]  w_letter_out;
    logic        w_fb;

    assign w_lower     = (r_ch >= 8'h61) && (r_ch <= 8'h7A);
    assign w_upper     = w_lower ? (r_ch - 8'h20) : r_ch;
    assign w_is_letter = (w_upper >= 8'h41) && (w_upper <= 8'h5A);

    // Both operands are below 26, so one conditional subtract gives mod 26
    assign w_raw = r_dec ? (r_idx + 8'd26 - r_k) : (r_idx + r_k);
    assign w_mod = (w_raw >= 8'd26) ? (w_raw - 8'd26) : w_raw;
    assign w_c   = 8'h41 + w_mod;

`ifdef CASE_PRESERVE_EN
    assign w_letter_out = r_was_lower ? (w_c | 8'h20) : w_c;
`else
    assign w_letter_out = w_c;
`endif

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign in_ready     = (r_state == S_IDLE) && !seed_load;
    assign busy         = (r_state != S_IDLE);
    assign out_valid    = r_out_valid;
    assign out_ch       = r_out_ch;
    assign letter_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch        <= 8'h00;
            r_dec       <= 1'b0;
            r_idx       <= 8'h00;
            r_is_letter <= 1'b0;
`ifdef CASE_PRESERVE_EN
            r_was_lower <= 1'b0;
`endif
            r_k         <= 8'h00;
            r_lfsr      <= SEED_DEFAULT;
            r_out_ch    <= 8'h00;
            r_out_valid <= 1'b0;
            r_count     <= 16'h0000;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
                    end else if (in_valid) begin
                        r_ch    <= in_ch;
                        r_dec   <= decrypt;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_idx       <= w_upper - 8'h41;
                    r_is_letter <= w_is_letter;
`ifdef CASE_PRESERVE_EN
                    r_was_lower <= w_lower;
`endif
                    r_state     <= S_KEY;
                end
                S_KEY: begin
                    r_k     <= r_lfsr % 8'd26;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_is_letter) begin
                        r_out_ch <= w_letter_out;
                        r_lfsr   <= {r_lfsr[6:0], w_fb};
                        r_count  <= r_count + 16'd1;
                    end else begin
                        r_out_ch <= r_ch;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_cipher_ctrl.sv
// Directed self-checking bench for lfsr_cipher_ctrl (default and CASE_PRESERVE_EN builds).
`timescale 1ns/1ps
module tb_lfsr_cipher_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ch;
    logic        decrypt;
    logic        seed_load;
    logic [7:0]  seed;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ch;
    logic        busy;
    logic [15:0] letter_count;

    int n_checks;
    int n_fail;

`ifdef CASE_PRESERVE_EN
    localparam logic [7:0] EXP_A_ENC = 8'h6A;
`else
    localparam logic [7:0] EXP_A_ENC = 8'h4A;
`endif

    lfsr_cipher_ctrl #(.SEED_DEFAULT(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ch        (in_ch),
        .decrypt      (decrypt),
        .seed_load    (seed_load),
        .seed         (seed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ch       (out_ch),
        .busy         (busy),
        .letter_count (letter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one char, flip decrypt after accept, wait bounded for out_valid.
    task automatic run_char(input logic [7:0] ch, input logic dec,
                            output logic [7:0] res, output int lat);
        int waits;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch;
        decrypt  = dec;
        @(negedge clk);
        in_valid = 1'b0;
        decrypt  = ~dec;
        waits = 0;
        while (!out_valid && waits < 12) begin
            @(negedge clk);
            waits++;
        end
        lat = waits + 1;
        res = out_ch;
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [7:0] r;
    int         lat;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ch     = 8'h00;
        decrypt   = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(letter_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'hA5);
        rst = 1'b0;

        // 'a' encrypt, k = 0xA5 % 26 = 9
        run_char(8'h61, 1'b0, r, lat);
        chk("a_latency", 32'(lat), 32'd4);
        chk("a_out", 32'(r), 32'(EXP_A_ENC));
        chk("a_in_ready_busy", 32'(in_ready), 32'd0);
        finish_out();
        chk("a_out_valid_drop", 32'(out_valid), 32'd0);
        chk("a_lfsr", 32'(dut.r_lfsr), 32'h4A);
        chk("a_count", 32'(letter_count), 32'd1);

        // 'Z' encrypt, k = 74 % 26 = 22
        run_char(8'h5A, 1'b0, r, lat);
        chk("Z_out", 32'(r), 32'h56);
        finish_out();
        chk("Z_count", 32'(letter_count), 32'd2);
        chk("Z_lfsr", 32'(dut.r_lfsr), 32'h95);

        // Non-letter passes through untouched
        run_char(8'h23, 1'b0, r, lat);
        chk("hash_out", 32'(r), 32'h23);
        finish_out();
        chk("hash_lfsr", 32'(dut.r_lfsr), 32'h95);
        chk("hash_count", 32'(letter_count), 32'd2);

        // seed_load beats a simultaneous in_valid
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 8'hA5;
        in_valid  = 1'b1;
        in_ch     = 8'h51;
        #1;
        chk("seed_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        seed_load = 1'b0;
        in_valid  = 1'b0;
        chk("seed_not_accepted", 32'(busy), 32'd0);
        chk("seed_lfsr", 32'(dut.r_lfsr), 32'hA5);

        run_char(8'h4A, 1'b1, r, lat);
        chk("J_decrypt", 32'(r), 32'h41);
        finish_out();
        chk("J_count", 32'(letter_count), 32'd3);

        // Zero seed is replaced with 1
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed0_lfsr", 32'(dut.r_lfsr), 32'h01);
        run_char(8'h41, 1'b0, r, lat);
        chk("A_k1_out", 32'(r), 32'h42);
        finish_out();
        chk("A_k1_lfsr", 32'(dut.r_lfsr), 32'h02);

        // Back-pressure: 'C' with k=2 -> 'E', held for 10 cycles
        run_char(8'h43, 1'b0, r, lat);
        chk("C_out", 32'(r), 32'h45);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_ch     = 8'h78;
            seed_load = (i == 4);
            seed      = 8'h33;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_ch", 32'(out_ch), 32'h45);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        seed_load = 1'b0;
        finish_out();
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_lfsr", 32'(dut.r_lfsr), 32'h04);
        chk("bp_count", 32'(letter_count), 32'd5);

        // Reset while in SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 8'h61;
        decrypt  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_lfsr", 32'(dut.r_lfsr), 32'hA5);
        chk("midrst_count", 32'(letter_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_char(8'h61, 1'b0, r, lat);
        chk("post_rst_a", 32'(r), 32'(EXP_A_ENC));
        finish_out();
        chk("post_rst_count", 32'(letter_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
